mcu_spi_arbiter: RTL and testbench

- Shares the single MCU SPI link (chip select, MOSI, SCK enable) between two requesters: the RTC bridge engine (requester 0) and the CPU-driven SPI controller (requester 1).
- Grants whole CS-framed transactions with round-robin priority and inserts a CS-high guard gap between owners.
- A watchdog forcibly reclaims the bus from an owner that holds CS with no clock activity.
- Sits between the requester engines and the MCU pins, in the SClk domain.

---
 rtl/mcu_spi_arb_pkg.sv | 28 ++
 rtl/arb_watchdog.sv | 33 +++
 rtl/mcu_spi_arbiter.sv | 156 +++++++++++++++
 tb/tb_mcu_spi_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mcu_spi_arb_pkg.sv
// Shared types and encodings for the MCU SPI link arbiter.
package mcu_spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_RTC = 2'd1,
    GRANT_SPI = 2'd2,
    GUARD     = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_RTC  = 2'd1;
  localparam logic [1:0] OWNER_SPI  = 2'd2;

  localparam int unsigned REQ_RTC = 0;
  localparam int unsigned REQ_SPI = 1;
  localparam int unsigned NUM_REQ = 2;

  // BusOwner encoding implied by an arbiter state.
  function automatic logic [1:0] owner_of(arb_state_e s);
    logic [1:0] o;
    o = OWNER_NONE;
    if (s == GRANT_RTC) o = OWNER_RTC;
    if (s == GRANT_SPI) o = OWNER_SPI;
    return o;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Saturating stall counter; flags expiry once it reaches TIMEOUT_CYCLES.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Clear wins; otherwise count enabled cycles, holding at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_c = (cnt_q == TW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mcu_spi_arbiter.sv
// Round-robin owner of the MCU SPI pins with CS guard gap and stall watchdog.
module mcu_spi_arbiter
  import mcu_spi_arb_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       SClk,
  input  logic       Reset,
  input  logic       RTCnSel,
  input  logic       RTCDo,
  input  logic       RTCClkRun,
  input  logic       RTCClkStretch,
  output logic       RTCGrant,
  input  logic       SPInSel,
  input  logic       SPIDo,
  input  logic       SPIClkRun,
  output logic       SPIGrant,
  output logic       MCUnSel,
  output logic       MCUDo,
  output logic       MCUClkEn,
  output logic [1:0] BusOwner,
  output logic       TimeoutErr,
  input  logic       ErrClear
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = 4;

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        guard_q, guard_d;
  logic                 rr_q, rr_d;
  logic [NUM_REQ-1:0]   lock_q, lock_d;
  logic                 err_q, err_d;
  logic                 grant_rtc_q, grant_rtc_d;
  logic                 grant_spi_q, grant_spi_d;
  logic [1:0]           owner_q, owner_d;
  logic                 req_rtc_c, req_spi_c;
  logic                 granted_c;
  logic                 wd_expire_c;

  assign req_rtc_c = ~RTCnSel & ~lock_q[REQ_RTC];
  assign req_spi_c = ~SPInSel & ~lock_q[REQ_SPI];
  assign granted_c = (state_q == GRANT_RTC) || (state_q == GRANT_SPI);

  // Route only the owner's CS/MOSI/clock request to the pins.
  always_comb begin
    MCUnSel  = 1'b1;
    MCUDo    = 1'b1;
    MCUClkEn = 1'b0;
    case (state_q)
      GRANT_RTC: begin
        MCUnSel  = RTCnSel;
        MCUDo    = RTCDo;
        MCUClkEn = RTCClkRun & ~RTCClkStretch;
      end
      GRANT_SPI: begin
        MCUnSel  = SPInSel;
        MCUDo    = SPIDo;
        MCUClkEn = SPIClkRun;
      end
      default: ;
    endcase
  end

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW            (TW)
  ) u_watchdog (
    .clk     (SClk),
    .rst     (Reset),
    .clr     (~granted_c | MCUClkEn),
    .en      (granted_c),
    .expire_c(wd_expire_c)
  );

  // Arbitration, release/timeout handling, guard countdown and sticky error.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    err_d   = err_q;
    if (RTCnSel)  lock_d[REQ_RTC] = 1'b0;
    if (SPInSel)  lock_d[REQ_SPI] = 1'b0;
    if (ErrClear) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_rtc_c && (!req_spi_c || (rr_q == 1'(REQ_RTC)))) begin
          state_d = GRANT_RTC;
        end else if (req_spi_c) begin
          state_d = GRANT_SPI;
        end
      end
      GRANT_RTC: begin
        if (RTCnSel || wd_expire_c) begin
          state_d = GUARD;
          guard_d = '0;
          rr_d    = 1'(REQ_SPI);
          if (!RTCnSel) begin
            err_d           = 1'b1;
            lock_d[REQ_RTC] = 1'b1;
          end
        end
      end
      GRANT_SPI: begin
        if (SPInSel || wd_expire_c) begin
          state_d = GUARD;
          guard_d = '0;
          rr_d    = 1'(REQ_RTC);
          if (!SPInSel) begin
            err_d           = 1'b1;
            lock_d[REQ_SPI] = 1'b1;
          end
        end
      end
      GUARD: begin
        if (guard_q == GW'(GUARD_CYCLES - 1)) state_d = IDLE;
        else                                  guard_d = guard_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    grant_rtc_d = (state_d == GRANT_RTC);
    grant_spi_d = (state_d == GRANT_SPI);
    owner_d     = owner_of(state_d);
  end

  // State and registered status outputs.
  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      guard_q     <= '0;
      rr_q        <= 1'(REQ_RTC);
      lock_q      <= '0;
      err_q       <= 1'b0;
      grant_rtc_q <= 1'b0;
      grant_spi_q <= 1'b0;
      owner_q     <= OWNER_NONE;
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
      grant_rtc_q <= grant_rtc_d;
      grant_spi_q <= grant_spi_d;
      owner_q     <= owner_d;
    end
  end

  assign RTCGrant   = grant_rtc_q;
  assign SPIGrant   = grant_spi_q;
  assign BusOwner   = owner_q;
  assign TimeoutErr = err_q;

endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// Directed + randomized bench for mcu_spi_arbiter against a transaction-level model.
module tb_mcu_spi_arbiter;

  localparam int G = 2;
  localparam int T = 16;

  logic       SClk, Reset;
  logic       RTCnSel, RTCDo, RTCClkRun, RTCClkStretch, RTCGrant;
  logic       SPInSel, SPIDo, SPIClkRun, SPIGrant;
  logic       MCUnSel, MCUDo, MCUClkEn, TimeoutErr, ErrClear;
  logic [1:0] BusOwner;

  int tests = 0;
  int fails = 0;

  // Model: who owns the link, how many guard cycles remain, consecutive
  // stalled owner cycles, preferred requester (1/2), lockouts, error flag.
  int m_owner, m_guard, m_stall, m_rr;
  int m_lock[3];
  bit m_err;

  mcu_spi_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .SClk(SClk), .Reset(Reset),
    .RTCnSel(RTCnSel), .RTCDo(RTCDo), .RTCClkRun(RTCClkRun),
    .RTCClkStretch(RTCClkStretch), .RTCGrant(RTCGrant),
    .SPInSel(SPInSel), .SPIDo(SPIDo), .SPIClkRun(SPIClkRun), .SPIGrant(SPIGrant),
    .MCUnSel(MCUnSel), .MCUDo(MCUDo), .MCUClkEn(MCUClkEn),
    .BusOwner(BusOwner), .TimeoutErr(TimeoutErr), .ErrClear(ErrClear)
  );

  initial SClk = 1'b0;
  always #5 SClk = ~SClk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_guard = 0; m_stall = 0; m_rr = 1; m_err = 1'b0;
    for (int i = 0; i < 3; i++) m_lock[i] = 0;
  endtask

  // Compare every output with what the model says the pins should show now.
  task automatic check_all();
    logic e_nsel, e_do, e_clk;
    e_nsel = 1'b1; e_do = 1'b1; e_clk = 1'b0;
    if (m_owner == 1) begin
      e_nsel = RTCnSel; e_do = RTCDo; e_clk = RTCClkRun & ~RTCClkStretch;
    end else if (m_owner == 2) begin
      e_nsel = SPInSel; e_do = SPIDo; e_clk = SPIClkRun;
    end
    chk("rtc_grant", 2'(RTCGrant), 2'(m_owner == 1));
    chk("spi_grant", 2'(SPIGrant), 2'(m_owner == 2));
    chk("bus_owner", BusOwner, 2'(m_owner));
    chk("mcu_nsel", 2'(MCUnSel), 2'(e_nsel));
    chk("mcu_do", 2'(MCUDo), 2'(e_do));
    chk("mcu_clken", 2'(MCUClkEn), 2'(e_clk));
    chk("timeout_err", 2'(TimeoutErr), 2'(m_err));
  endtask

  // Advance the model over one clock edge using the current inputs.
  task automatic model_step();
    bit own_nsel, own_clk, to, r1, r2;
    int lock_set;
    to = 1'b0; lock_set = 0;
    if (m_owner != 0) begin
      own_nsel = (m_owner == 1) ? RTCnSel : SPInSel;
      own_clk  = (m_owner == 1) ? (RTCClkRun & ~RTCClkStretch) : SPIClkRun;
      if (own_nsel) begin
        m_rr = 3 - m_owner; m_owner = 0; m_guard = G;
      end else if (m_stall == T) begin
        to = 1'b1; lock_set = m_owner;
        m_rr = 3 - m_owner; m_owner = 0; m_guard = G;
      end else begin
        m_stall = own_clk ? 0 : ((m_stall < T) ? m_stall + 1 : T);
      end
    end else if (m_guard > 0) begin
      m_guard--;
    end else begin
      r1 = !RTCnSel && (m_lock[1] == 0);
      r2 = !SPInSel && (m_lock[2] == 0);
      if (r1 && (!r2 || m_rr == 1)) begin m_owner = 1; m_stall = 0; end
      else if (r2)                  begin m_owner = 2; m_stall = 0; end
    end
    if (lock_set == 1) m_lock[1] = 1; else if (RTCnSel) m_lock[1] = 0;
    if (lock_set == 2) m_lock[2] = 1; else if (SPInSel) m_lock[2] = 0;
    if (to) m_err = 1'b1; else if (ErrClear) m_err = 1'b0;
  endtask

  // Called at a falling edge with inputs already set: check, then cross one cycle.
  task automatic step();
    #1;
    check_all();
    model_step();
    @(negedge SClk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      RTCDo = 1'($urandom); SPIDo = 1'($urandom);
      step();
    end
  endtask

  initial begin
    Reset = 1'b1;
    RTCnSel = 1'b1; RTCDo = 1'b0; RTCClkRun = 1'b0; RTCClkStretch = 1'b0;
    SPInSel = 1'b1; SPIDo = 1'b0; SPIClkRun = 1'b0; ErrClear = 1'b0;
    model_reset();
    @(negedge SClk); @(negedge SClk);
    #1 check_all();
    @(negedge SClk);
    Reset = 1'b0;

    // Simultaneous requests after reset: RTC first, SPI after the guard gap.
    RTCnSel = 1'b0; SPInSel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      RTCClkRun = 1'($urandom); SPIClkRun = 1'($urandom); steps(1);
    end
    chk("pair_rtc_first", BusOwner, 2'd1);
    RTCnSel = 1'b1; steps(1);
    chk("guard_no_grant", 2'(SPIGrant), 2'd0);
    steps(2);
    chk("guard_still_low", 2'(SPIGrant), 2'd0);
    steps(1);
    chk("spi_after_guard", 2'(SPIGrant), 2'd1);
    for (int i = 0; i < 4; i++) begin SPIClkRun = 1'($urandom); steps(1); end
    SPInSel = 1'b1; steps(4);

    // RTC alone with a toggling clock request.
    RTCnSel = 1'b0; steps(1);
    chk("rtc_latency", 2'(RTCGrant), 2'd1);
    for (int i = 0; i < 6; i++) begin RTCClkRun = ~RTCClkRun; steps(1); end
    RTCnSel = 1'b1; steps(1);
    chk("rtc_released", 2'(RTCGrant), 2'd0);
    steps(4);

    // Next simultaneous pair goes to SPI; RTC waits behind it.
    RTCnSel = 1'b0; SPInSel = 1'b0; RTCClkRun = 1'b1; SPIClkRun = 1'b1; steps(1);
    chk("pair_spi_first", BusOwner, 2'd2);
    steps(2);
    SPInSel = 1'b1; steps(4);
    chk("rtc_after_spi", BusOwner, 2'd1);

    // Clock stretch below the timeout: stall counts but clears on resume.
    RTCClkStretch = 1'b1; steps(14);
    RTCClkStretch = 1'b0; steps(3);
    chk("stretch_no_err", 2'(TimeoutErr), 2'd0);
    chk("stretch_kept", 2'(RTCGrant), 2'd1);
    RTCnSel = 1'b1; RTCClkRun = 1'b0; steps(4);

    // SPI stalls with CS low: forced release, error, lockout until CS toggles.
    SPInSel = 1'b0; SPIClkRun = 1'b0; steps(20);
    chk("timeout_err_set", 2'(TimeoutErr), 2'd1);
    chk("timeout_released", 2'(SPIGrant), 2'd0);
    steps(4);
    ErrClear = 1'b1; steps(1); ErrClear = 1'b0;
    steps(4);
    chk("err_cleared", 2'(TimeoutErr), 2'd0);
    chk("locked_out", 2'(SPIGrant), 2'd0);
    SPInSel = 1'b1; steps(1);
    SPInSel = 1'b0; steps(1);
    chk("regrant_after_toggle", 2'(SPIGrant), 2'd1);

    // Second timeout with ErrClear in the same cycle: set wins.
    steps(16);
    ErrClear = 1'b1; steps(1); ErrClear = 1'b0;
    chk("set_beats_clear", 2'(TimeoutErr), 2'd1);
    chk("second_release", 2'(SPIGrant), 2'd0);
    SPInSel = 1'b1; ErrClear = 1'b1; steps(1); ErrClear = 1'b0;
    chk("clear_alone", 2'(TimeoutErr), 2'd0);
    steps(3);

    // Asynchronous reset mid-grant, then a pending SPI-only request.
    RTCnSel = 1'b0; RTCClkRun = 1'b1; steps(3);
    #2 Reset = 1'b1;
    #1;
    chk("rst_mcu_nsel", 2'(MCUnSel), 2'd1);
    chk("rst_rtc_grant", 2'(RTCGrant), 2'd0);
    chk("rst_bus_owner", BusOwner, 2'd0);
    model_reset();
    RTCnSel = 1'b1; SPInSel = 1'b0;
    @(negedge SClk);
    #1 check_all();
    @(negedge SClk);
    Reset = 1'b0;
    steps(1);
    chk("post_rst_spi", 2'(SPIGrant), 2'd1);
    SPInSel = 1'b1; steps(4);

    // Randomized traffic with occasional long stalls.
    begin
      bit stall_mode;
      stall_mode = 1'b0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 99) < 8)  RTCnSel = ~RTCnSel;
        if ($urandom_range(0, 99) < 8)  SPInSel = ~SPInSel;
        if ($urandom_range(0, 99) < 3)  stall_mode = ~stall_mode;
        RTCClkRun     = stall_mode ? 1'b0 : 1'($urandom);
        SPIClkRun     = stall_mode ? 1'b0 : 1'($urandom);
        RTCClkStretch = ($urandom_range(0, 99) < 20);
        ErrClear      = ($urandom_range(0, 99) < 3);
        steps(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
